// File: rtl/add_tree_acc.sv
// add_tree_acc: registered binary adder tree over N_IN signed operands,
// followed by a bias/accumulate stage and a saturate + ReLU output stage.
// Latency from ivalid to ovalid is log2(N_IN)+2 cycles. OUT_W must not exceed ACC_W.
module add_tree_acc #(
    parameter int unsigned N_IN   = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IN*DATA_W-1:0]   din,
    input  logic [DATA_W-1:0]        bias,
    input  logic                     ivalid,
    input  logic                     ifirst,
    input  logic                     ilast,
    input  logic                     acc_mode,
    input  logic                     relu_en,
    output logic                     ovalid,
    output logic [OUT_W-1:0]         dout,
    output logic                     osat
);

    localparam int unsigned S     = $clog2(N_IN);
    localparam int unsigned TW    = DATA_W + S;
    localparam int unsigned NODES = N_IN - 1;
    localparam int unsigned ROOT  = N_IN - 2;
    localparam int unsigned BW    = S * DATA_W;
    localparam int unsigned HW    = ACC_W - OUT_W + 1;

    // Tree nodes are stored flat, stage by stage; stage s starts at N_IN - (N_IN >> s).
    function automatic int unsigned stage_off(input int unsigned s);
        return N_IN - (N_IN >> s);
    endfunction

    function automatic logic [TW-1:0] sext_op(input logic [DATA_W-1:0] x);
        return {{S{x[DATA_W-1]}}, x};
    endfunction

    logic [NODES*TW-1:0] tree_d, tree_q;
    logic [S-1:0]        vld_d, vld_q;
    logic [S-1:0]        first_d, first_q;
    logic [S-1:0]        last_d, last_q;
    logic [BW-1:0]       bias_d, bias_q;

    logic [TW-1:0]       root_sum;
    logic [DATA_W-1:0]   bias_tail;
    logic [ACC_W-1:0]    sum_ext, bias_ext;
    logic [ACC_W-1:0]    acc_d, acc_q;
    logic                res_vld_d, res_vld_q;

    logic [HW-1:0]       acc_hi;
    logic                ovf;
    logic [OUT_W-1:0]    sat_val;
    logic [OUT_W-1:0]    dout_d, dout_q;
    logic                osat_d, osat_q;
    logic                ovalid_d, ovalid_q;

    // Tree adders: leaves pair the input operands, later stages pair the previous stage.
    always_comb begin
        tree_d = '0;
        for (int unsigned k = 0; k < N_IN / 2; k++) begin
            tree_d[k*TW +: TW] = sext_op(din[(2*k)*DATA_W +: DATA_W])
                               + sext_op(din[(2*k+1)*DATA_W +: DATA_W]);
        end
        for (int unsigned s = 1; s < S; s++) begin
            for (int unsigned k = 0; k < (N_IN >> (s + 1)); k++) begin
                tree_d[(stage_off(s)+k)*TW +: TW] =
                    tree_q[(stage_off(s-1)+2*k)*TW +: TW]
                  + tree_q[(stage_off(s-1)+2*k+1)*TW +: TW];
            end
        end
    end

    // Side-band shift registers travel alongside the tree.
    always_comb begin
        vld_d   = (vld_q << 1)   | S'(ivalid);
        first_d = (first_q << 1) | S'(ifirst);
        last_d  = (last_q << 1)  | S'(ilast);
        bias_d  = BW'({bias_q, bias});
    end

    // Tree and side-band pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tree_q  <= '0;
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            bias_q  <= '0;
        end else begin
            tree_q  <= tree_d;
            vld_q   <= vld_d;
            first_q <= first_d;
            last_q  <= last_d;
            bias_q  <= bias_d;
        end
    end

    // Accumulate stage: per-beat sum+bias, or group accumulation between ifirst and ilast.
    always_comb begin
        root_sum  = tree_q[ROOT*TW +: TW];
        bias_tail = bias_q[(S-1)*DATA_W +: DATA_W];
        sum_ext   = {{(ACC_W-TW){root_sum[TW-1]}}, root_sum};
        bias_ext  = {{(ACC_W-DATA_W){bias_tail[DATA_W-1]}}, bias_tail};
        acc_d     = acc_q;
        res_vld_d = 1'b0;
        if (vld_q[S-1]) begin
            if (!acc_mode || first_q[S-1]) begin
                acc_d = sum_ext + bias_ext;
            end else begin
                acc_d = acc_q + sum_ext;
            end
            res_vld_d = !acc_mode || last_q[S-1];
        end
    end

    // Output stage: saturate to OUT_W, then optional ReLU; hold when no result.
    always_comb begin
        acc_hi   = acc_q[ACC_W-1:OUT_W-1];
        ovf      = (|acc_hi) && !(&acc_hi);
        sat_val  = acc_q[OUT_W-1:0];
        if (ovf) begin
            sat_val = acc_q[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}};
        end
        dout_d   = dout_q;
        osat_d   = osat_q;
        ovalid_d = res_vld_q;
        if (res_vld_q) begin
            dout_d = (relu_en && sat_val[OUT_W-1]) ? '0 : sat_val;
            osat_d = ovf;
        end
    end

    // Accumulator and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q     <= '0;
            res_vld_q <= 1'b0;
            dout_q    <= '0;
            osat_q    <= 1'b0;
            ovalid_q  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            res_vld_q <= res_vld_d;
            dout_q    <= dout_d;
            osat_q    <= osat_d;
            ovalid_q  <= ovalid_d;
        end
    end

    assign ovalid = ovalid_q;
    assign dout   = dout_q;
    assign osat   = osat_q;

endmodule

// File: tb/tb_add_tree_acc.sv
// Bench for add_tree_acc: default-config instance plus a 16-bit instance for saturation.
module tb_add_tree_acc;

    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int OW  = 32;
    localparam int AW  = 48;
    localparam int DW2 = 16;
    localparam int OW2 = 16;
    localparam int AW2 = 24;
    localparam int LAT = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, ivalid, ivalid16, ifirst, ilast, acc_mode, relu_en;
    logic [N*DW-1:0]   din;
    logic [DW-1:0]     bias;
    logic [N*DW2-1:0]  din16;
    logic [DW2-1:0]    bias16;
    logic              ovalid, osat, ovalid16, osat16;
    logic [OW-1:0]     dout;
    logic [OW2-1:0]    dout16;

    add_tree_acc #(.N_IN(N), .DATA_W(DW), .OUT_W(OW), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .bias(bias), .ivalid(ivalid),
        .ifirst(ifirst), .ilast(ilast), .acc_mode(acc_mode), .relu_en(relu_en),
        .ovalid(ovalid), .dout(dout), .osat(osat)
    );

    add_tree_acc #(.N_IN(N), .DATA_W(DW2), .OUT_W(OW2), .ACC_W(AW2)) dut16 (
        .clk(clk), .rst_n(rst_n), .din(din16), .bias(bias16), .ivalid(ivalid16),
        .ifirst(ifirst), .ilast(ilast), .acc_mode(acc_mode), .relu_en(relu_en),
        .ovalid(ovalid16), .dout(dout16), .osat(osat16)
    );

    typedef struct {
        logic signed [31:0] d;
        logic               s;
        int                 c;
    } res_t;

    res_t exp_q[$], obs_q[$], exp16_q[$], obs16_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture every output beat with its cycle stamp.
    always @(negedge clk) begin
        if (ovalid)   obs_q.push_back('{$signed(dout), osat, cyc});
        if (ovalid16) obs16_q.push_back('{32'($signed(dout16)), osat16, cyc});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ivalid = 1'b0; ivalid16 = 1'b0; ifirst = 1'b0; ilast = 1'b0;
        end
    endtask

    // Main-instance beat: operand k = base + step*k.
    task automatic drive(input int base, input int step, input int b,
                         input logic f, input logic l, output int c);
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) din[k*DW +: DW] = 32'(base + step*k);
        bias = 32'(b); ifirst = f; ilast = l; ivalid = 1'b1; ivalid16 = 1'b0;
        c = cyc;
    endtask

    task automatic drive16(input int v, input int b, output int c);
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) din16[k*DW2 +: DW2] = 16'(v);
        bias16 = 16'(b); ifirst = 1'b0; ilast = 1'b0; ivalid16 = 1'b1; ivalid = 1'b0;
        c = cyc;
    endtask

    // Wait (bounded) until outputs catch up with expectations, then let the pipe empty.
    task automatic settle();
        for (int t = 0; t < 100 && (obs_q.size() < exp_q.size() || obs16_q.size() < exp16_q.size()); t++)
            idle(1);
        idle(LAT + 3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ivalid = 1'b0; ivalid16 = 1'b0; ifirst = 1'b0; ilast = 1'b0;
        acc_mode = 1'b0; relu_en = 1'b0; din = '0; bias = '0; din16 = '0; bias16 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ovalid, osat, dout} !== {1'b0, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL reset_main: got ovalid=%0b osat=%0b dout=%0d, want 0 0 0", ovalid, osat, dout);
        end
        n_checks++;
        if ({ovalid16, osat16, dout16} !== {1'b0, 1'b0, 16'd0}) begin
            n_fail++; $display("FAIL reset_16: got ovalid=%0b osat=%0b dout=%0d, want 0 0 0", ovalid16, osat16, dout16);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single();
        int c; res_t o, e;
        drive(1, 0, 10, 1'b0, 1'b0, c);
        exp_q.push_back('{32'sd18, 1'b0, c + LAT});
        settle();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL single count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o.d !== e.d || o.s !== e.s || o.c !== e.c) begin
                n_fail++; $display("FAIL single result: got dout=%0d osat=%0b cyc=%0d, want dout=%0d osat=%0b cyc=%0d", o.d, o.s, o.c, e.d, e.s, e.c);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int c; res_t o, e;
        for (int i = 0; i < 20; i++) begin
            drive(i, 1, -5, 1'b0, 1'b0, c);
            exp_q.push_back('{32'(8*i + 28 - 5), 1'b0, c + LAT});
        end
        settle();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL b2b count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o.d !== e.d || o.s !== e.s || o.c !== e.c) begin
                n_fail++; $display("FAIL b2b result: got dout=%0d osat=%0b cyc=%0d, want dout=%0d osat=%0b cyc=%0d", o.d, o.s, o.c, e.d, e.s, e.c);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_accumulate();
        int c; res_t o, e;
        acc_mode = 1'b1;
        drive(2, 0, 100, 1'b1, 1'b0, c);
        drive(3, 0, 100, 1'b0, 1'b0, c);
        idle(2);
        drive(4, 0, 100, 1'b0, 1'b1, c);
        exp_q.push_back('{32'sd172, 1'b0, c + LAT});
        // A second ifirst abandons the open group.
        drive(7, 0, 50, 1'b1, 1'b0, c);
        drive(1, 0, 3, 1'b1, 1'b0, c);
        drive(1, 0, 3, 1'b0, 1'b1, c);
        exp_q.push_back('{32'sd19, 1'b0, c + LAT});
        settle();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL acc count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o.d !== e.d || o.s !== e.s || o.c !== e.c) begin
                n_fail++; $display("FAIL acc result: got dout=%0d osat=%0b cyc=%0d, want dout=%0d osat=%0b cyc=%0d", o.d, o.s, o.c, e.d, e.s, e.c);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturation();
        int c; res_t o, e;
        acc_mode = 1'b0; relu_en = 1'b0;
        drive16(20000, 0, c);  exp16_q.push_back('{32'sd32767,  1'b1, c + LAT});
        drive16(-20000, 0, c); exp16_q.push_back('{-32'sd32768, 1'b1, c + LAT});
        drive16(4096, 0, c);   exp16_q.push_back('{32'sd32767,  1'b1, c + LAT});
        drive16(-4096, 0, c);  exp16_q.push_back('{-32'sd32768, 1'b0, c + LAT});
        drive16(4095, 7, c);   exp16_q.push_back('{32'sd32767,  1'b0, c + LAT});
        settle();
        relu_en = 1'b1;
        drive16(-20000, 0, c); exp16_q.push_back('{32'sd0,   1'b1, c + LAT});
        drive16(100, -900, c); exp16_q.push_back('{32'sd0,   1'b0, c + LAT});
        drive16(50, 5, c);     exp16_q.push_back('{32'sd405, 1'b0, c + LAT});
        settle();
        relu_en = 1'b0;
        n_checks++;
        if (obs16_q.size() !== exp16_q.size()) begin
            n_fail++; $display("FAIL sat count: got %0d, want %0d", obs16_q.size(), exp16_q.size());
        end
        while (obs16_q.size() > 0 && exp16_q.size() > 0) begin
            o = obs16_q.pop_front(); e = exp16_q.pop_front(); n_checks++;
            if (o.d !== e.d || o.s !== e.s || o.c !== e.c) begin
                n_fail++; $display("FAIL sat result: got dout=%0d osat=%0b cyc=%0d, want dout=%0d osat=%0b cyc=%0d", o.d, o.s, o.c, e.d, e.s, e.c);
            end
        end
        n_checks++;
        if (obs_q.size() !== 0) begin
            n_fail++; $display("FAIL sat idle_main: got %0d outputs, want 0", obs_q.size());
        end
        exp16_q.delete(); obs16_q.delete(); obs_q.delete();
    endtask

    task automatic test_single_group_relu();
        int c; res_t o, e;
        acc_mode = 1'b1; relu_en = 1'b1;
        drive(-3, 0, 4, 1'b1, 1'b1, c);
        exp_q.push_back('{32'sd0, 1'b0, c + LAT});
        settle();
        relu_en = 1'b0;
        drive(-3, 0, 4, 1'b1, 1'b1, c);
        exp_q.push_back('{-32'sd20, 1'b0, c + LAT});
        settle();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL relu count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o.d !== e.d || o.s !== e.s || o.c !== e.c) begin
                n_fail++; $display("FAIL relu result: got dout=%0d osat=%0b cyc=%0d, want dout=%0d osat=%0b cyc=%0d", o.d, o.s, o.c, e.d, e.s, e.c);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_midflight_reset();
        int c; res_t o, e;
        acc_mode = 1'b1; relu_en = 1'b0;
        drive(5, 0, 0, 1'b1, 1'b0, c);
        drive(5, 0, 0, 1'b0, 1'b1, c);
        idle(1);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        n_checks++;
        if ({ovalid, osat, dout} !== {1'b0, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL rst_mid state: got ovalid=%0b osat=%0b dout=%0d, want 0 0 0", ovalid, osat, dout);
        end
        settle();
        n_checks++;
        if (obs_q.size() !== 0) begin
            n_fail++; $display("FAIL rst_mid discard: got %0d outputs, want 0", obs_q.size());
        end
        obs_q.delete();
        drive(1, 0, 0, 1'b1, 1'b1, c);
        exp_q.push_back('{32'sd8, 1'b0, c + LAT});
        settle();
        // After another reset, ilast alone adds onto the cleared accumulator.
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        drive(2, 0, 99, 1'b0, 1'b1, c);
        exp_q.push_back('{32'sd16, 1'b0, c + LAT});
        settle();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rst_mid count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o.d !== e.d || o.s !== e.s || o.c !== e.c) begin
                n_fail++; $display("FAIL rst_mid result: got dout=%0d osat=%0b cyc=%0d, want dout=%0d osat=%0b cyc=%0d", o.d, o.s, o.c, e.d, e.s, e.c);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_accumulate();
        test_saturation();
        test_single_group_relu();
        test_midflight_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_tree_acc.md
Name: add_tree_acc

Overview:
- Parametrised successor to the two-operand pipelined adder, used by the conv layer to sum the N_IN per-kernel-row/per-channel products.
- Sums N_IN signed operands in a registered binary tree, then adds a bias.
- Optionally accumulates across several input beats (channel batches), then saturates to OUT_W and applies ReLU.
- Sits between the multiplier array and the feature-map write-back.

Parameters:
- N_IN, 8, number of signed operands per beat; power of 2, ≥2.
- DATA_W, 32, width of each operand and of bias.
- OUT_W, 32, width of dout; saturation target.
- ACC_W, 48, accumulator width; must be ≥ DATA_W+log2(N_IN)+1.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- din, input, N_IN*DATA_W, packed signed operands; operand k at bits [k*DATA_W +: DATA_W].
- bias, input, DATA_W, signed bias; sampled with ifirst (acc mode) or every valid beat (non-acc mode).
- ivalid, input, 1, din/bias/ifirst/ilast valid this cycle.
- ifirst, input, 1, first beat of an accumulation group (acc mode only).
- ilast, input, 1, last beat of an accumulation group (acc mode only).
- acc_mode, input, 1, 0 = per-beat sum, 1 = accumulate ifirst..ilast; quasi-static.
- relu_en, input, 1, 1 = clamp negative results to 0; quasi-static.
- ovalid, output, 1, dout valid for one cycle.
- dout, output, OUT_W, signed result.
- osat, output, 1, saturation occurred on this dout; qualified by ovalid.

Behaviour:
- Reset (rst_n=0 at clk edge): all pipeline data registers, the valid/ifirst/ilast shift registers, the accumulator, dout, ovalid and osat go to 0. In-flight data is discarded; no ovalid is produced for beats accepted before reset.
- Tree: S = log2(N_IN) registered stages; each stage adds pairs, sign-extended by 1 bit per stage. No overflow or truncation inside the tree.
- Stage S+1 (accumulate):
  - acc_mode=0: r = tree_sum + sext(bias), computed at ACC_W.
  - acc_mode=1 and valid&first: acc <= tree_sum + sext(bias).
  - acc_mode=1 and valid&!first: acc <= acc + tree_sum.
  - Otherwise acc holds its value.
  - Accumulator wraps two's-complement at ACC_W; sizing is the integrator's responsibility.
- Stage S+2 (output):
  - Saturate the ACC_W value to OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1]; osat=1 if clamped.
  - Then, if relu_en and the value is negative, dout = 0 (osat unchanged).
  - dout/osat are registered; ovalid is registered.
- Latency: L = log2(N_IN)+2 cycles from ivalid to ovalid. Default L = 5.
- ovalid:
  - acc_mode=0: ovalid asserts L cycles after every ivalid beat.
  - acc_mode=1: ovalid asserts L cycles after a beat with ilast=1 only, and carries the accumulator value including that beat.
- Throughput: one beat per cycle, fully pipelined, no back-pressure; ivalid gaps are allowed anywhere, including inside an accumulation group (acc holds).
- ifirst and ilast in the same beat form a single-beat group: output = sum+bias.
- ifirst while a group is open: the old group is abandoned without output and acc restarts.
- ilast without a prior ifirst since reset: adds onto the current acc (0 after reset) and outputs it.
- ifirst/ilast are ignored when ivalid=0 and when acc_mode=0.
- acc_mode and relu_en may only change when no beats are in flight; behaviour otherwise is undefined and not checked.
- When ovalid=0, dout and osat hold their last values.

Test Plan:
1. Defaults, acc_mode=0, relu_en=0, din all = 1, bias=10, one beat → ovalid exactly 5 cycles later, dout=18, osat=0.
2. acc_mode=0, 20 back-to-back beats with din[k]=beat_index+k and bias=-5 → 20 consecutive ovalid cycles, each dout = 8*i+28-5 in order, no gaps.
3. acc_mode=1, bias=100, 3-beat group with din all = 2, 3, 4 and 2 idle cycles between beats 2 and 3 → single ovalid 5 cycles after the ilast beat, dout = 100+16+24+32 = 172.
4. Saturation with OUT_W=16: din all = 16'h7FFF-scale values (DATA_W=16, each 20000), bias=0 → dout=32767, osat=1. All -20000 with relu_en=0 → dout=-32768, osat=1. Same with relu_en=1 → dout=0, osat=1.
5. ifirst&ilast on the same beat, din all = -3, bias=4, relu_en=1 → dout=0 (-20 clamped). Repeat with relu_en=0 → dout=-20.
6. rst_n low for one cycle two cycles after an ilast beat → no ovalid from that group. The next group (ifirst, din all 1, bias 0, ilast) outputs 8, showing acc was cleared.
